// File: rtl/alu_chain_pkg.sv
// Shared types and constants for the multi-byte ALU sequencer.
package alu_chain_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;

    // Byte-index counter width; a single-byte build still needs one bit.
    function automatic int unsigned idx_width(input int unsigned nbytes);
        return (nbytes <= 1) ? 1 : $clog2(nbytes);
    endfunction

endpackage

// File: rtl/alu_chain.sv
// Multi-byte sequencer driving an external 8-bit combinational ALU, LSB byte first.
// Optional feature: define ALU_CHAIN_ZERO_EN to build the registered result-is-zero flag.
module alu_chain
    import alu_chain_pkg::*;
#(
    parameter int unsigned NBYTES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [3:0]            req_op_i,
    input  logic [8*NBYTES-1:0]   req_a_i,
    input  logic [8*NBYTES-1:0]   req_b_i,
    input  logic                  req_cin_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [8*NBYTES-1:0]   rsp_data_o,
    output logic                  rsp_cout_o,
    output logic                  rsp_zero_o,
    output logic [7:0]            alu_a_o,
    output logic [7:0]            alu_b_o,
    output logic                  alu_cin_o,
    output logic [3:0]            alu_sel_o,
    input  logic [7:0]            alu_out_i,
    input  logic                  alu_cout_i
);

    localparam int unsigned IdxW = idx_width(NBYTES);
    localparam int unsigned W    = 8 * NBYTES;

    state_e          state_q;
    logic [IdxW-1:0] idx_q;
    logic            carry_q;
    logic [3:0]      op_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    res_q;
    logic [W-1:0]    res_d;
    logic            cout_q;
    logic [7:0]      a_byte;
    logic [7:0]      b_byte;
    logic            running;
    logic            last_byte;

    // Byte select and result write-back share the same index decode.
    always_comb begin
        a_byte = '0;
        b_byte = '0;
        res_d  = res_q;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            if (idx_q == IdxW'(i)) begin
                a_byte           = a_q[8*i +: 8];
                b_byte           = b_q[8*i +: 8];
                res_d[8*i +: 8]  = alu_out_i;
            end
        end
    end

    assign running   = (state_q == StRun);
    assign last_byte = (idx_q == IdxW'(NBYTES - 1));

    assign alu_a_o   = running ? a_byte  : '0;
    assign alu_b_o   = running ? b_byte  : '0;
    assign alu_cin_o = running ? carry_q : 1'b0;
    assign alu_sel_o = running ? op_q    : '0;

    assign req_ready_o = (state_q == StIdle);
    assign rsp_valid_o = (state_q == StDone);
    assign rsp_data_o  = res_q;
    assign rsp_cout_o  = cout_q;

`ifdef ALU_CHAIN_ZERO_EN
    logic zero_q;
    assign rsp_zero_o = zero_q;
`else
    assign rsp_zero_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
`ifdef ALU_CHAIN_ZERO_EN
            zero_q  <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        op_q    <= req_op_i;
                        a_q     <= req_a_i;
                        b_q     <= req_b_i;
                        carry_q <= req_cin_i;
                        idx_q   <= '0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    res_q   <= res_d;
                    carry_q <= alu_cout_i;
                    if (last_byte) begin
                        cout_q  <= alu_cout_i;
`ifdef ALU_CHAIN_ZERO_EN
                        zero_q  <= (res_d == '0);
`endif
                        state_q <= StDone;
                    end else begin
                        idx_q <= idx_q + IdxW'(1);
                    end
                end
                StDone: begin
                    if (rsp_ready_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
